// File: rtl/frame_reader.sv
// Streams one frame from a synchronous read-only memory to a valid/ready pixel stream.
// Optional trailing zero-pixel flush is compiled in with FRAME_READER_FLUSH_EN.
module frame_reader #(
    parameter int PIXEL_DEPTH = 8,
    parameter int WIDTH       = 8,
    parameter int HEIGHT      = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int FLUSH_COUNT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [PIXEL_DEPTH-1:0] mem_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_DEPTH-1:0] out_pixel,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
    localparam logic [XW-1:0] LAST_X = XW'(WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(HEIGHT - 1);

    if (WIDTH < 2 || HEIGHT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        FLUSH_COUNT < 1 || ((WIDTH * HEIGHT - 1) >> ADDR_WIDTH) != 0) begin : g_bad_params
        $error("frame_reader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
    logic                    rd_pending_q;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW:0]             count_q, count_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [PIXEL_DEPTH-1:0]  fifo_mem [FIFO_DEPTH];
`ifdef FRAME_READER_FLUSH_EN
    localparam int FW = $clog2(FLUSH_COUNT + 1);
    localparam logic [FW-1:0] LAST_FLUSH = FW'(FLUSH_COUNT - 1);
    logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
`endif

    logic                    fifo_valid;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    logic [CW-1:0]           inflight;

    always_comb begin
        state_d     = state_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        next_addr_d = next_addr_q;
        x_d         = x_q;
        y_d         = y_q;
`ifdef FRAME_READER_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif
        busy        = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
        done        = (state_q == S_DONE);

        fifo_valid  = (count_q != '0);
        out_valid   = fifo_valid;
        out_pixel   = '0;
        out_sof     = 1'b0;
        out_eol     = 1'b0;
        out_eof     = 1'b0;
        if (fifo_valid) begin
            out_pixel = fifo_mem[rd_ptr_q];
            out_sof   = (x_q == '0) && (y_q == '0);
            out_eol   = (x_q == LAST_X);
            out_eof   = (x_q == LAST_X) && (y_q == LAST_Y);
        end

        push     = rd_pending_q;
        pop      = fifo_valid && out_ready;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);

        // Everything that will land in the FIFO must still fit after this cycle's pop.
        inflight  = CW'(count_q) + CW'(rd_pending_q) + CW'(mem_rd_en_q);
        credit_ok = inflight < (CW'(FIFO_DEPTH) + CW'(pop));

        if (pop) begin
            if (x_q == LAST_X) begin
                x_d = '0;
                y_d = (y_q == LAST_Y) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_READ;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = '0;
                    next_addr_d = ADDR_WIDTH'(1);
                    x_d         = '0;
                    y_d         = '0;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    if (next_addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && out_eof) begin
`ifdef FRAME_READER_FLUSH_EN
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
`else
                    state_d     = S_DONE;
`endif
                end
            end
`ifdef FRAME_READER_FLUSH_EN
            S_FLUSH: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (flush_cnt_q == LAST_FLUSH) begin
                        state_d = S_DONE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FW'(1);
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            next_addr_q  <= '0;
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
`ifdef FRAME_READER_FLUSH_EN
            flush_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            next_addr_q  <= next_addr_d;
            rd_pending_q <= mem_rd_en_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
`ifdef FRAME_READER_FLUSH_EN
            flush_cnt_q  <= flush_cnt_d;
`endif
        end
    end

    // Storage is not reset; the occupancy count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rd_data;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: scoreboard of expected beats, checked at each transfer.
module tb_frame_reader;
    localparam int PD = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 16;
    localparam int FD = 4;
    localparam int FC = 8;
    localparam int N  = W * H;
`ifdef FRAME_READER_FLUSH_EN
    localparam int NF = FC;
`else
    localparam int NF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [PD-1:0] mem_rd_data = '0;
    logic          out_valid, out_sof, out_eol, out_eof;
    logic [PD-1:0] out_pixel;

    frame_reader #(
        .PIXEL_DEPTH(PD), .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW),
        .FIFO_DEPTH(FD), .FLUSH_COUNT(FC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0] + 8'd1;
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int done_seen = 0;
    int t_start = 0;
    bit chk_timing = 1'b0;
    bit last_final = 1'b0;
    bit prev_stall = 1'b0;
    logic [11:0] prev_vals = '0;
    logic [10:0] exp_beat;
    logic [10:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_final = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (done || last_final) check("done_pulse", {31'd0, done}, {31'd0, last_final});
            if (done) done_seen++;
            if (prev_stall)
                check("stall_hold", {20'd0, out_valid, out_pixel, out_sof, out_eol, out_eof}, {20'd0, prev_vals});
            if (mem_rd_en) begin
                rd_cnt++;
                check("credit_limit", {31'd0, (rd_cnt - acc_cnt) <= FD}, 32'd1);
            end
            last_final = 1'b0;
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat_pix_sof_eol_eof", {21'd0, out_pixel, out_sof, out_eol, out_eof}, {21'd0, exp_beat});
                    if (chk_timing) check("beat_cycle", cycle, t_start + 2 + acc_cnt);
                    if (sb.size() == 0) last_final = 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_vals  = {out_valid, out_pixel, out_sof, out_eol, out_eof};
        end
    end

    task automatic start_frame(input bit push);
        if (push) begin
            for (int a = 0; a < N; a++)
                sb.push_back({8'(a + 1), (a == 0), ((a % W) == W - 1), (a == N - 1)});
            for (int f = 0; f < NF; f++)
                sb.push_back(11'd0);
            rd_cnt  = 0;
            acc_cnt = 0;
        end
        @(posedge clk); #1 start = 1'b1; t_start = cycle;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("first_rd_en", {31'd0, mem_rd_en}, 32'd1);
        check("first_addr", {16'd0, mem_addr}, 32'd0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_frame(input int mode, input int max_cyc);
        int d0;
        int i;
        d0 = done_seen;
        i = 0;
        while (done_seen == d0 && i < max_cyc) begin
            @(posedge clk); #1;
            if (mode == 1) out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            i++;
        end
        check("frame_completed", {31'd0, done_seen > d0}, 32'd1);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {25'd0, busy, done, mem_rd_en, out_valid, out_sof, out_eol, out_eof}, 32'd0);
        check("reset_addr", {16'd0, mem_addr}, 32'd0);
        check("reset_pixel", {24'd0, out_pixel}, 32'd0);
        rst_n = 1'b1;

        // back-to-back frame, full throughput
        out_ready = 1'b1;
        chk_timing = 1'b1;
        start_frame(1'b1);
        run_frame(0, 100);

        // ready pattern 1,0,0,1
        chk_timing = 1'b0;
        start_frame(1'b1);
        run_frame(1, 300);
        check("stalled_beats", acc_cnt, N + NF);

        // downstream blocked: only FIFO_DEPTH reads
        out_ready = 1'b0;
        start_frame(1'b1);
        repeat (12) @(negedge clk);
        check("blocked_reads", rd_cnt, FD);
        check("blocked_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("blocked_valid", {31'd0, out_valid}, 32'd1);
        check("blocked_pixel", {24'd0, out_pixel}, 32'd1);
        check("blocked_sof", {31'd0, out_sof}, 32'd1);
        out_ready = 1'b1;
        run_frame(0, 100);

        // second start while reading is dropped
        chk_timing = 1'b1;
        out_ready = 1'b1;
        d0 = done_seen;
        start_frame(1'b1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_frame(0, 100);
        repeat (6) @(posedge clk);
        check("single_done", done_seen - d0, 32'd1);
        check("single_frame_beats", acc_cnt, N + NF);

        // reset at the 5th beat, then a fresh frame
        start_frame(1'b1);
        for (int i = 0; i < 50 && acc_cnt < 4; i++) @(posedge clk);
        #1;
        check("reached_beat5", acc_cnt, 32'd4);
        rst_n = 1'b0;
        #2;
        check("midreset_ctrl", {25'd0, busy, done, mem_rd_en, out_valid, out_sof, out_eol, out_eof}, 32'd0);
        check("midreset_addr", {16'd0, mem_addr}, 32'd0);
        check("midreset_pixel", {24'd0, out_pixel}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_frame(1'b1);
        run_frame(0, 100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
